crossbar_arbiter: RTL and testbench

CROSSBAR_ARBITER -- requirements
Module: crossbar_arbiter

---
 rtl/crossbar_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_crossbar_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/crossbar_arbiter.sv
// 4x4 crossbar arbiter: one IDLE/BUSY round-robin arbiter per output, packet-locked grants.
// Optional stall timeout enabled by defining XBAR_TIMEOUT_EN.
module crossbar_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  input  logic [1:0] dst0,
  input  logic [1:0] dst1,
  input  logic [1:0] dst2,
  input  logic [1:0] dst3,
  input  logic       last0,
  input  logic       last1,
  input  logic       last2,
  input  logic       last3,
  output logic       gnt0,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic [3:0] sel0,
  output logic [3:0] sel1,
  output logic [3:0] sel2,
  output logic [3:0] sel3,
  output logic [3:0] out_busy,
  output logic [3:0] to_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  logic [3:0] req_v, last_v, gnt_v;
  logic [1:0] dst_v [4];
  logic [3:0] sel_m [4];
  state_t     state_r [4];
  state_t     state_nx [4];
  logic [1:0] owner_r [4];
  logic [1:0] owner_nx [4];
  logic [1:0] ptr_r [4];
  logic [1:0] ptr_nx [4];
  logic [3:0] cand, rot;
  logic [7:0] rot8;
  logic [1:0] off, win;
  logic       beat;

`ifdef XBAR_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_r [4];
  logic [CW-1:0] cnt_nx [4];
  logic [3:0]    err_nx, to_err_r;
  assign to_err = to_err_r;
`else
  assign to_err = 4'b0000;
`endif

  assign req_v  = {req3, req2, req1, req0};
  assign last_v = {last3, last2, last1, last0};
  assign dst_v[0] = dst0;
  assign dst_v[1] = dst1;
  assign dst_v[2] = dst2;
  assign dst_v[3] = dst3;

  assign gnt0 = gnt_v[0];
  assign gnt1 = gnt_v[1];
  assign gnt2 = gnt_v[2];
  assign gnt3 = gnt_v[3];
  assign sel0 = sel_m[0];
  assign sel1 = sel_m[1];
  assign sel2 = sel_m[2];
  assign sel3 = sel_m[3];

  // Decode select matrix, grants and busy flags from registered ownership.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        sel_m[j][k] = (state_r[k] == BUSY) && (owner_r[k] == j[1:0]);
      end
    end
    for (int j = 0; j < 4; j++) begin
      gnt_v[j] = |sel_m[j];
    end
    for (int k = 0; k < 4; k++) begin
      out_busy[k] = (state_r[k] == BUSY);
    end
  end

  // Per-output arbitration, release and optional stall timeout.
  always_comb begin
    cand = 4'b0000;
    rot  = 4'b0000;
    rot8 = 8'h00;
    off  = 2'd0;
    win  = 2'd0;
    beat = 1'b0;
`ifdef XBAR_TIMEOUT_EN
    err_nx = 4'b0000;
`endif
    for (int k = 0; k < 4; k++) begin
      state_nx[k] = state_r[k];
      owner_nx[k] = owner_r[k];
      ptr_nx[k]   = ptr_r[k];
`ifdef XBAR_TIMEOUT_EN
      cnt_nx[k]   = cnt_r[k];
`endif
      for (int i = 0; i < 4; i++) begin
        cand[i] = req_v[i] && (dst_v[i] == k[1:0]) && !gnt_v[i];
      end
      // Rotate so that bit 0 is the pointer position, then take the lowest hit.
      rot8 = {cand, cand} >> ptr_r[k];
      rot  = rot8[3:0];
      if (rot[0])      off = 2'd0;
      else if (rot[1]) off = 2'd1;
      else if (rot[2]) off = 2'd2;
      else             off = 2'd3;
      win  = ptr_r[k] + off;
      beat = req_v[owner_r[k]];
      case (state_r[k])
        IDLE: begin
`ifdef XBAR_TIMEOUT_EN
          cnt_nx[k] = {CW{1'b0}};
`endif
          if (|rot) begin
            state_nx[k] = BUSY;
            owner_nx[k] = win;
            ptr_nx[k]   = win + 2'd1;
          end else begin
            state_nx[k] = IDLE;
          end
        end
        BUSY: begin
`ifdef XBAR_TIMEOUT_EN
          if (beat && last_v[owner_r[k]]) begin
            state_nx[k] = IDLE;
            cnt_nx[k]   = {CW{1'b0}};
          end else if (beat) begin
            cnt_nx[k]   = {CW{1'b0}};
          end else if (cnt_r[k] == CW'(TIMEOUT - 1)) begin
            state_nx[k] = IDLE;
            err_nx[k]   = 1'b1;
            cnt_nx[k]   = {CW{1'b0}};
          end else begin
            cnt_nx[k]   = cnt_r[k] + CW'(1);
          end
`else
          if (beat && last_v[owner_r[k]]) begin
            state_nx[k] = IDLE;
          end else begin
            state_nx[k] = BUSY;
          end
`endif
        end
        default: state_nx[k] = IDLE;
      endcase
    end
  end

  // Ownership, pointer and timeout state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        state_r[k] <= IDLE;
        owner_r[k] <= 2'd0;
        ptr_r[k]   <= 2'd0;
`ifdef XBAR_TIMEOUT_EN
        cnt_r[k]   <= {CW{1'b0}};
`endif
      end
`ifdef XBAR_TIMEOUT_EN
      to_err_r <= 4'b0000;
`endif
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_r[k] <= state_nx[k];
        owner_r[k] <= owner_nx[k];
        ptr_r[k]   <= ptr_nx[k];
`ifdef XBAR_TIMEOUT_EN
        cnt_r[k]   <= cnt_nx[k];
`endif
      end
`ifdef XBAR_TIMEOUT_EN
      to_err_r <= err_nx;
`endif
    end
  end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Directed self-checking bench for crossbar_arbiter (TIMEOUT=4; timeout steps when XBAR_TIMEOUT_EN is defined).
module tb_crossbar_arbiter;
  logic clk, rst_n;
  logic req0, req1, req2, req3;
  logic [1:0] dst0, dst1, dst2, dst3;
  logic last0, last1, last2, last3;
  logic gnt0, gnt1, gnt2, gnt3;
  logic [3:0] sel0, sel1, sel2, sel3, out_busy, to_err;
  logic [3:0] gnt_all;
  logic [15:0] sel_all;
  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] exp_g [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                            4'b0000, 4'b1000, 4'b0000, 4'b0001};

  assign gnt_all = {gnt3, gnt2, gnt1, gnt0};
  assign sel_all = {sel3, sel2, sel1, sel0};

  crossbar_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .req2(req2), .req3(req3),
    .dst0(dst0), .dst1(dst1), .dst2(dst2), .dst3(dst3),
    .last0(last0), .last1(last1), .last2(last2), .last3(last3),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3),
    .sel0(sel0), .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .out_busy(out_busy), .to_err(to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [7:0] d, input logic [3:0] l);
    {req3, req2, req1, req0} = r;
    {dst3, dst2, dst1, dst0} = d;
    {last3, last2, last1, last0} = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 8'h00, 4'b0000);
    #3;
    check("rst_gnt", {12'h000, gnt_all}, 16'h0000);
    check("rst_sel", sel_all, 16'h0000);
    check("rst_busy", {12'h000, out_busy}, 16'h0000);
    check("rst_toerr", {12'h000, to_err}, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single grant: input 0 to output 2
    drive(4'b0001, 8'b00000010, 4'b0000);
    tick();
    check("g0_gnt", {12'h000, gnt_all}, 16'h0001);
    check("g0_sel", sel_all, 16'h0004);
    check("g0_busy", {12'h000, out_busy}, 16'h0004);
    drive(4'b0001, 8'b00000010, 4'b0001);
    tick();
    check("g0_rel_gnt", {12'h000, gnt_all}, 16'h0000);
    check("g0_rel_busy", {12'h000, out_busy}, 16'h0000);
    drive(4'b0000, 8'h00, 4'b0000);
    tick();

    // Parallel grants i->i, then stall, then release
    drive(4'b1111, 8'b11100100, 4'b0000);
    tick();
    check("par_gnt", {12'h000, gnt_all}, 16'h000f);
    check("par_sel", sel_all, 16'h8421);
    check("par_busy", {12'h000, out_busy}, 16'h000f);
    drive(4'b0000, 8'b11100100, 4'b0000);
    tick();
    check("stall_gnt", {12'h000, gnt_all}, 16'h000f);
    drive(4'b1111, 8'b11100100, 4'b1111);
    tick();
    check("par_rel_gnt", {12'h000, gnt_all}, 16'h0000);
    check("par_rel_busy", {12'h000, out_busy}, 16'h0000);
    drive(4'b0000, 8'h00, 4'b0000);
    tick();

    // Owner changes dst mid-packet: grant stays latched on output 3
    drive(4'b0100, 8'b00110000, 4'b0000);
    tick();
    check("dst_gnt", {12'h000, gnt_all}, 16'h0004);
    check("dst_sel", sel_all, 16'h0800);
    drive(4'b0100, 8'b00000000, 4'b0000);
    tick();
    check("dst_hold_sel", sel_all, 16'h0800);
    check("dst_hold_busy", {12'h000, out_busy}, 16'h0008);
    drive(4'b0100, 8'b00000000, 4'b0100);
    tick();
    check("dst_rel_gnt", {12'h000, gnt_all}, 16'h0000);
    check("dst_rel_busy", {12'h000, out_busy}, 16'h0000);
    drive(4'b0000, 8'h00, 4'b0000);
    tick();

    // Asynchronous reset mid-packet (input 1 owns output 1, pointer moves to 2)
    drive(4'b0010, 8'b00000100, 4'b0000);
    tick();
    check("ar_gnt", {12'h000, gnt_all}, 16'h0002);
    check("ar_sel", sel_all, 16'h0020);
    #2 rst_n = 1'b0;
    #1;
    check("ar_clr_gnt", {12'h000, gnt_all}, 16'h0000);
    check("ar_clr_sel", sel_all, 16'h0000);
    check("ar_clr_busy", {12'h000, out_busy}, 16'h0000);
    drive(4'b0000, 8'h00, 4'b0000);
    #1 rst_n = 1'b1;

    // Round robin on output 1 from a reset pointer: 0,1,2,3,0 with bubbles
    drive(4'b1111, 8'b01010101, 4'b1111);
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("rr_gnt%0d", i), {12'h000, gnt_all}, {12'h000, exp_g[i]});
    end
    drive(4'b0001, 8'b01010101, 4'b0001);
    tick();
    check("rr_rel_gnt", {12'h000, gnt_all}, 16'h0000);
    drive(4'b0000, 8'h00, 4'b0000);
    tick();

    // Owner stalls on output 0 while input 1 waits
    drive(4'b0001, 8'h00, 4'b0000);
    tick();
    check("to_grant", {12'h000, gnt_all}, 16'h0001);
    drive(4'b0010, 8'h00, 4'b0000);
`ifdef XBAR_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("to_wait_err%0d", i), {12'h000, to_err}, 16'h0000);
      check($sformatf("to_wait_gnt%0d", i), {12'h000, gnt_all}, 16'h0001);
    end
    tick();
    check("to_err_pulse", {12'h000, to_err}, 16'h0001);
    check("to_err_busy", {12'h000, out_busy}, 16'h0000);
    check("to_err_gnt", {12'h000, gnt_all}, 16'h0000);
    tick();
    check("to_next_gnt", {12'h000, gnt_all}, 16'h0002);
    check("to_err_clear", {12'h000, to_err}, 16'h0000);
`else
    repeat (8) tick();
    check("hold_gnt", {12'h000, gnt_all}, 16'h0001);
    check("hold_toerr", {12'h000, to_err}, 16'h0000);
    drive(4'b0011, 8'h00, 4'b0001);
    tick();
    check("hold_rel_gnt", {12'h000, gnt_all}, 16'h0000);
    drive(4'b0010, 8'h00, 4'b0000);
    tick();
    check("hold_next_gnt", {12'h000, gnt_all}, 16'h0002);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
